// File: rtl/pc_seq_if.sv
// Control/status bundle between the control unit and the fetch-stage
// program counter sequencer. The control unit drives the decoded
// requests; the sequencer returns the fetch address and its flags.
interface pc_seq_if #(
    parameter int PC_W      = 16,
    parameter int OFF_W     = 8,
    parameter int STK_DEPTH = 4
);
    localparam int CNT_W = $clog2(STK_DEPTH + 1);

    logic             stall;
    logic             jump_en;
    logic             branch_en;
    logic             call_en;
    logic             ret_en;
    logic             halt_req;
    logic [PC_W-1:0]  Target;
    logic [OFF_W-1:0] Offset;

    logic [PC_W-1:0]  PC;
    logic             halt;
    logic             fault;
    logic [CNT_W-1:0] stk_cnt;

    // Control unit side: issues requests, observes the sequencer.
    modport master (
        output stall, jump_en, branch_en, call_en, ret_en, halt_req,
               Target, Offset,
        input  PC, halt, fault, stk_cnt
    );

    // Sequencer side: consumes requests, presents PC and status.
    modport slave (
        input  stall, jump_en, branch_en, call_en, ret_en, halt_req,
               Target, Offset,
        output PC, halt, fault, stk_cnt
    );
endinterface

// File: rtl/pc_seq.sv
// Program counter and sequencer for the fetch stage.
// Holds the instruction-memory address, resolves jump/branch/call/return
// requests in a fixed priority order, keeps a return-address stack, and
// stops in a sticky HALTED state on request, on reaching HALT_ADDR, or on
// a stack overflow/underflow (which also raises the sticky fault flag).
// All outputs come straight from registers.
module pc_seq #(
    parameter int              PC_W       = 16,
    parameter int              OFF_W      = 8,
    parameter logic [PC_W-1:0] RESET_ADDR = '0,
    parameter logic [PC_W-1:0] HALT_ADDR  = {PC_W{1'b1}},
    parameter int              STK_DEPTH  = 4
) (
    input  logic   CLK,
    input  logic   init,
    pc_seq_if.slave bus
);
    localparam int CNT_W = $clog2(STK_DEPTH + 1);
    localparam int IDX_W = (STK_DEPTH > 1) ? $clog2(STK_DEPTH) : 1;

    // The halt flag doubles as the state encoding.
    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    logic [0:0]      state_q, state_d;
    logic [PC_W-1:0] pc_q, pc_d;
    logic            fault_q, fault_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            push;

    logic [PC_W-1:0] stk_q [STK_DEPTH];

    logic [PC_W-1:0]  pcInc;
    logic [PC_W-1:0]  offExt;
    logic [IDX_W-1:0] pushIdx;
    logic [IDX_W-1:0] topIdx;
    logic             stkEmpty;
    logic             stkFull;

    // Offset is two's complement; a signed size cast sign-extends it and
    // also copes with OFF_W == PC_W without a zero-width replication.
    assign offExt   = PC_W'($signed(bus.Offset));
    assign pcInc    = pc_q + PC_W'(1);
    assign pushIdx  = IDX_W'(cnt_q);
    assign topIdx   = IDX_W'(cnt_q - CNT_W'(1));
    assign stkEmpty = (cnt_q == '0);
    assign stkFull  = (cnt_q == CNT_W'(STK_DEPTH));

    // Next-state selection: the first matching rule wins, everything
    // below it is dropped for this cycle.
    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        fault_d = fault_q;
        cnt_d   = cnt_q;
        push    = 1'b0;
        if (state_q == ST_RUN && !bus.stall) begin
            if (bus.halt_req || pc_q == HALT_ADDR) begin
                state_d = ST_HALTED;
            end else if (bus.ret_en) begin
                if (stkEmpty) begin
                    fault_d = 1'b1;
                    state_d = ST_HALTED;
                end else begin
                    pc_d  = stk_q[topIdx];
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end else if (bus.call_en) begin
                if (stkFull) begin
                    fault_d = 1'b1;
                    state_d = ST_HALTED;
                end else begin
                    push  = 1'b1;
                    pc_d  = bus.Target;
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end else if (bus.jump_en) begin
                pc_d = bus.Target;
            end else if (bus.branch_en) begin
                pc_d = pc_q + offExt;
            end else begin
                pc_d = pcInc;
            end
        end
    end

    // Architectural state; init wins over everything, including HALTED.
    always_ff @(posedge CLK) begin
        if (init) begin
            state_q <= ST_RUN;
            pc_q    <= RESET_ADDR;
            fault_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            fault_q <= fault_d;
            cnt_q   <= cnt_d;
        end
    end

    // Return-address storage; contents are meaningless above cnt_q so no reset.
    always_ff @(posedge CLK) begin
        if (!init && push) begin
            stk_q[pushIdx] <= pcInc;
        end
    end

    assign bus.PC      = pc_q;
    assign bus.halt    = (state_q == ST_HALTED);
    assign bus.fault   = fault_q;
    assign bus.stk_cnt = cnt_q;

endmodule
